// File: rtl/layer_generator_pkg.sv
// Shared widths, LFSR polynomial, FSM encoding and path helpers for the
// layer generator.
package layer_generator_pkg;

  localparam int LAYER_WIDTH = 7;
  localparam int LFSR_WIDTH  = 16;
  // x^16 + x^14 + x^13 + x^11 + 1 as taps on a left-shifting register
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [2:0] LAST_COL = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_READY   = 3'd2,
    ST_DELAY   = 3'd3,
    ST_EMIT    = 3'd4
  } state_t;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
    return {v[LFSR_WIDTH-2:0], ^(v & LFSR_TAPS)};
  endfunction

  // Safe column walks one step; edges bounce back inward.
  function automatic logic [2:0] path_step(input logic [2:0] p, input logic up);
    logic [2:0] n;
    if (p == 3'd0)          n = 3'd1;
    else if (p == LAST_COL) n = LAST_COL - 3'd1;
    else if (up)            n = p + 3'd1;
    else                    n = p - 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/layer_generator_lfsr.sv
// Free-running Fibonacci LFSR; reloads its seed whenever cleared.
module layer_lfsr
  import layer_generator_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  i_clr,
  output logic [LFSR_WIDTH-1:0] o_lfsr
);

  logic [LFSR_WIDTH-1:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (i_clr) r_lfsr <= SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/layer_generator.sv
// Generates block layers for the block-field shifter: preloads the visible
// field, then emits one layer per jump after a millisecond delay.
module layer_generator
  import layer_generator_pkg::*;
#(
  parameter int          NUM_LAYERS    = 5,
  parameter int          START_COL     = 3,
  parameter int          LOAD_DELAY_MS = 200,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       module_en,
  input  logic       one_ms_tick,
  input  logic       jump_left,
  input  logic       jump_right,
  output logic       load_layer,
  output logic [0:6] layer_map_out,
  output logic [0:6] block_type_out,
  output logic       busy
);

  localparam int DW = (LOAD_DELAY_MS > 1) ? $clog2(LOAD_DELAY_MS + 1) : 1;
  localparam int PW = $clog2(NUM_LAYERS + 1);
  localparam logic [DW-1:0] DELAY_INIT = DW'(LOAD_DELAY_MS);
  localparam logic [PW-1:0] PRE_LAST   = PW'(NUM_LAYERS);
  localparam logic [2:0]    START      = 3'(START_COL);

  state_t                  r_state;
  logic [PW-1:0]           r_pre_cnt;
  logic                    r_gap;
  logic [1:0]              r_pending;
  logic [DW-1:0]           r_delay_cnt;
  logic [2:0]              r_path_col;
  logic                    r_load;
  logic [0:LAYER_WIDTH-1]  r_map;
  logic [0:LAYER_WIDTH-1]  r_type;

  logic [LFSR_WIDTH-1:0]   w_lfsr;
  logic                    w_clr;
  logic                    w_jump;
  logic                    w_fire;
  logic [1:0]              w_pend_inc;
  logic [0:LAYER_WIDTH-1]  w_map;
  logic [0:LAYER_WIDTH-1]  w_type;

  assign w_clr      = rst | ~module_en;
  assign w_jump     = jump_left | jump_right;
  assign w_pend_inc = (r_pending == 2'd3) ? r_pending : r_pending + 2'd1;

  layer_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .i_clr  (w_clr),
    .o_lfsr (w_lfsr)
  );

  always_comb begin
    w_map  = '0;
    w_type = '0;
    for (int c = 0; c < LAYER_WIDTH; c++) begin
      if (3'(c) == r_path_col) begin
        w_map[c]  = 1'b1;
        w_type[c] = 1'b1;
      end else begin
        w_map[c]  = w_lfsr[c] & w_lfsr[c+7];
        w_type[c] = w_lfsr[c+8];
      end
    end
  end

  // A layer is committed on the same edge that raises load_layer.
  always_comb begin
    w_fire = 1'b0;
    case (r_state)
      ST_PRELOAD: w_fire = ~r_gap;
      ST_READY:   w_fire = (w_jump | (r_pending != 2'd0)) & (LOAD_DELAY_MS == 0);
      ST_DELAY:   w_fire = one_ms_tick & (r_delay_cnt == DW'(1));
      ST_EMIT:    w_fire = (w_jump | (r_pending != 2'd0)) & (LOAD_DELAY_MS == 0);
      default:    w_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state     <= ST_IDLE;
      r_pre_cnt   <= '0;
      r_gap       <= 1'b0;
      r_pending   <= 2'd0;
      r_delay_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state   <= ST_PRELOAD;
          r_pre_cnt <= '0;
          r_gap     <= 1'b0;
        end
        ST_PRELOAD: begin
          if (w_jump) r_pending <= w_pend_inc;
          r_gap <= ~r_gap;
          if (!r_gap)                      r_pre_cnt <= r_pre_cnt + PW'(1);
          else if (r_pre_cnt == PRE_LAST)  r_state   <= ST_READY;
        end
        ST_READY: begin
          // Jumps queued during preload are served without a fresh strobe.
          if (w_jump || r_pending != 2'd0) begin
            if (!w_jump) r_pending <= r_pending - 2'd1;
            if (LOAD_DELAY_MS == 0) begin
              r_state <= ST_EMIT;
            end else begin
              r_delay_cnt <= DELAY_INIT;
              r_state     <= ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (w_jump) r_pending <= w_pend_inc;
          if (one_ms_tick) begin
            r_delay_cnt <= r_delay_cnt - DW'(1);
            if (r_delay_cnt == DW'(1)) r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (!w_jump && r_pending != 2'd0) r_pending <= r_pending - 2'd1;
          if (w_jump || r_pending != 2'd0) begin
            if (LOAD_DELAY_MS == 0) begin
              r_state <= ST_EMIT;
            end else begin
              r_delay_cnt <= DELAY_INIT;
              r_state     <= ST_DELAY;
            end
          end else begin
            r_state <= ST_READY;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_load     <= 1'b0;
      r_map      <= '0;
      r_type     <= '0;
      r_path_col <= START;
    end else begin
      r_load <= w_fire;
      if (w_fire) begin
        r_map      <= w_map;
        r_type     <= w_type;
        r_path_col <= path_step(r_path_col, w_lfsr[LFSR_WIDTH-1]);
      end
    end
  end

  assign load_layer     = r_load;
  assign layer_map_out  = r_map;
  assign block_type_out = r_type;
  assign busy           = (r_state == ST_PRELOAD) || (r_state == ST_DELAY) ||
                          (r_state == ST_EMIT) || (r_pending != 2'd0);

endmodule

// File: tb/tb_layer_generator.sv
// Self-checking bench for layer_generator: timing of preload/delay/pending
// plus layer contents against a reference model of the path and LFSR rules.
module tb_layer_generator;

  localparam int          NUM   = 5;
  localparam int          START = 3;
  localparam int          DLY   = 200;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst, module_en, one_ms_tick, jump_left, jump_right;
  logic       load_layer, busy;
  logic [0:6] layer_map_out, block_type_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_p;
  logic [15:0] m_l     = SEED;
  logic [15:0] m_lprev = SEED;
  int tick_cyc [1:1000];

  typedef struct {
    int          ecyc;
    logic [0:6]  map;
    logic [0:6]  typ;
    logic [15:0] lprev;
  } ev_t;
  ev_t evq [$];
  ev_t first_run [NUM];

  layer_generator #(
    .NUM_LAYERS(NUM), .START_COL(START), .LOAD_DELAY_MS(DLY), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .one_ms_tick(one_ms_tick),
    .jump_left(jump_left), .jump_right(jump_right), .load_layer(load_layer),
    .layer_map_out(layer_map_out), .block_type_out(block_type_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] poly_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  function automatic int next_p(input int p, input logic up);
    if (p == 0) return 1;
    if (p == 6) return 5;
    return up ? p + 1 : p - 1;
  endfunction

  function automatic void model_layer(input logic [15:0] l, input int p,
                                      output logic [0:6] m, output logic [0:6] t);
    for (int c = 0; c < 7; c++) begin
      if (c == p) begin
        m[c] = 1'b1;
        t[c] = 1'b1;
      end else begin
        m[c] = l[c] & l[c+7];
        t[c] = l[c+8];
      end
    end
  endfunction

  // Reference LFSR sequence, advanced from the sampled inputs.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    m_lprev <= m_l;
    if (rst || !module_en) m_l <= SEED;
    else                   m_l <= poly_step(m_l);
  end

  always @(negedge clk) begin
    if (load_layer === 1'b1)
      evq.push_back('{ecyc: cyc, map: layer_map_out, typ: block_type_out, lprev: m_lprev});
  end

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic jump_once();
    jump_left = 1'b1;
    nclk();
    jump_left = 1'b0;
  endtask

  task automatic drive_ticks(input int n, input int j1, input int j2, input int j3,
                             input int j4, input int both_at);
    for (int i = 1; i <= n; i++) begin
      one_ms_tick = 1'b1;
      tick_cyc[i] = cyc;
      nclk();
      one_ms_tick = 1'b0;
      if (i == j1 || i == j2 || i == j3 || i == j4) jump_right = 1'b1;
      if (i == both_at) begin
        jump_left  = 1'b1;
        jump_right = 1'b1;
      end
      nclk();
      jump_left  = 1'b0;
      jump_right = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; module_en = 1'b1; one_ms_tick = 1'b0; jump_left = 1'b0; jump_right = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nclk();
      checks++;
      if ({load_layer, layer_map_out, block_type_out, busy} !== 16'h0000) begin
        errors++;
        $display("FAIL reset_outputs: got load=%b map=%b type=%b busy=%b, want all zero",
                 load_layer, layer_map_out, block_type_out, busy);
      end
    end
  endtask

  task automatic test_preload(input bit from_rst);
    int kd, n;
    ev_t e;
    logic [0:6] em, et;
    if (from_rst) rst = 1'b0;
    else          module_en = 1'b1;
    kd  = cyc;
    m_p = START;
    for (int i = 1; i <= 12; i++) begin
      nclk();
      checks++;
      if (busy !== (i <= 10)) begin
        errors++;
        $display("FAIL preload_busy: cycle +%0d got %b want %b", i, busy, (i <= 10));
      end
    end
    n = evq.size();
    checks++;
    if (n !== NUM) begin
      errors++;
      $display("FAIL preload_count: got %0d pulses want %0d", n, NUM);
    end
    for (int k = 0; k < NUM && evq.size() > 0; k++) begin
      e = evq.pop_front();
      model_layer(e.lprev, m_p, em, et);
      checks++;
      if (e.ecyc !== kd + 2 + 2 * k) begin
        errors++;
        $display("FAIL preload_timing: pulse %0d at cycle %0d want %0d", k, e.ecyc, kd + 2 + 2 * k);
      end
      checks++;
      if ({e.map, e.typ} !== {em, et}) begin
        errors++;
        $display("FAIL preload_layer: pulse %0d got map=%b type=%b want map=%b type=%b",
                 k, e.map, e.typ, em, et);
      end
      if (from_rst) begin
        first_run[k] = e;
      end else begin
        checks++;
        if ({e.map, e.typ} !== {first_run[k].map, first_run[k].typ}) begin
          errors++;
          $display("FAIL replay_layer: pulse %0d got map=%b type=%b want map=%b type=%b",
                   k, e.map, e.typ, first_run[k].map, first_run[k].typ);
        end
      end
      m_p = next_p(m_p, e.lprev[15]);
      if (k == NUM - 1) begin
        checks++;
        if (layer_map_out !== e.map) begin
          errors++;
          $display("FAIL preload_hold: map got %b want %b", layer_map_out, e.map);
        end
      end
    end
    evq.delete();
  endtask

  task automatic test_delay_timing();
    int tc, early;
    ev_t e;
    logic [0:6] em, et;
    early = 0;
    nclk();
    jump_once();
    for (int i = 1; i <= DLY; i++) begin
      one_ms_tick = 1'b1;
      tc = cyc;
      nclk();
      one_ms_tick = 1'b0;
      if (i == DLY) begin
        checks++;
        if (load_layer !== 1'b1) begin
          errors++;
          $display("FAIL delay_pulse: load_layer got %b want 1 one cycle after last tick", load_layer);
        end
      end
      nclk();
      if (i == DLY - 1) early = evq.size();
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL delay_early: got %0d pulses before last tick want 0", early);
    end
    checks++;
    if (evq.size() !== 1) begin
      errors++;
      $display("FAIL delay_count: got %0d pulses want 1", evq.size());
    end
    if (evq.size() > 0) begin
      e = evq.pop_front();
      model_layer(e.lprev, m_p, em, et);
      checks++;
      if (e.ecyc !== tc + 1 || {e.map, e.typ} !== {em, et}) begin
        errors++;
        $display("FAIL delay_layer: cycle %0d map=%b type=%b want cycle %0d map=%b type=%b",
                 e.ecyc, e.map, e.typ, tc + 1, em, et);
      end
      m_p = next_p(m_p, e.lprev[15]);
    end
    evq.delete();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL delay_busy: got %b want 0 after emit", busy);
    end
  endtask

  task automatic check_pending(input string name, input int nloads);
    ev_t e;
    logic [0:6] em, et;
    int n;
    n = evq.size();
    checks++;
    if (n !== nloads) begin
      errors++;
      $display("FAIL %s_count: got %0d loads want %0d", name, n, nloads);
    end
    for (int k = 1; k <= nloads && evq.size() > 0; k++) begin
      e = evq.pop_front();
      model_layer(e.lprev, m_p, em, et);
      checks++;
      if (e.ecyc !== tick_cyc[k * DLY] + 1 || {e.map, e.typ} !== {em, et}) begin
        errors++;
        $display("FAIL %s_load: load %0d cycle %0d map=%b type=%b want cycle %0d map=%b type=%b",
                 name, k, e.ecyc, e.map, e.typ, tick_cyc[k * DLY] + 1, em, et);
      end
      m_p = next_p(m_p, e.lprev[15]);
    end
    evq.delete();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: got %b want 0", name, busy);
    end
  endtask

  task automatic test_pending_merge();
    nclk();
    jump_once();
    drive_ticks(650, 30, -1, -1, -1, 10);
    check_pending("pend_merge", 3);
  endtask

  task automatic test_pending_saturate();
    nclk();
    jump_once();
    drive_ticks(850, 20, 40, 60, 80, -1);
    check_pending("pend_sat", 4);
  endtask

  task automatic test_random_walk(input int iters);
    int tcount, sel;
    ev_t e;
    logic [0:6] em, et;
    for (int it = 0; it < iters; it++) begin
      repeat ($urandom_range(0, 3)) nclk();
      sel = $urandom_range(0, 2);
      jump_left  = (sel != 1);
      jump_right = (sel != 0);
      nclk();
      jump_left  = 1'b0;
      jump_right = 1'b0;
      tcount = 0;
      while (evq.size() == 0 && tcount < 2 * DLY) begin
        one_ms_tick = 1'b1;
        nclk();
        one_ms_tick = 1'b0;
        tcount++;
        repeat ($urandom_range(1, 3)) nclk();
      end
      checks++;
      if (tcount !== DLY || evq.size() !== 1) begin
        errors++;
        $display("FAIL walk_timing: iter %0d ticks %0d loads %0d want %0d ticks 1 load",
                 it, tcount, evq.size(), DLY);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL walk_busy: iter %0d got %b want 0", it, busy);
      end
      if (evq.size() > 0) begin
        e = evq.pop_front();
        model_layer(e.lprev, m_p, em, et);
        checks++;
        if ({e.map, e.typ} !== {em, et}) begin
          errors++;
          $display("FAIL walk_layer: iter %0d path %0d got map=%b type=%b want map=%b type=%b",
                   it, m_p, e.map, e.typ, em, et);
        end
        m_p = next_p(m_p, e.lprev[15]);
      end
      evq.delete();
    end
  endtask

  task automatic test_abort();
    nclk();
    jump_once();
    drive_ticks(50, 20, -1, -1, -1, -1);
    module_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nclk();
      checks++;
      if ({load_layer, layer_map_out, block_type_out, busy} !== 16'h0000) begin
        errors++;
        $display("FAIL abort_outputs: got load=%b map=%b type=%b busy=%b, want all zero",
                 load_layer, layer_map_out, block_type_out, busy);
      end
    end
    checks++;
    if (evq.size() !== 0) begin
      errors++;
      $display("FAIL abort_pulse: got %0d loads before disable want 0", evq.size());
    end
    evq.delete();
    test_preload(1'b0);
    drive_ticks(300, -1, -1, -1, -1, -1);
    checks++;
    if (evq.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_pending: got %0d loads busy=%b want 0 loads busy=0", evq.size(), busy);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preload(1'b1);
    test_delay_timing();
    test_pending_merge();
    test_pending_saturate();
    test_random_walk(40);
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
